pay_station_ctrl: RTL and testbench
===================================

# pay_station_ctrl

Exit-side pay station controller that answers the parking system's billing handshake. On a rising `fee_ready` it latches `fee`, collects coins until the credit covers the fee, then issues the one-cycle `payment_received` pulse that releases the exit gate and reports change. Cancel or inactivity refunds the collected credit without paying. It sits between the coin acceptor hardware and the parking system's `fee_ready`/`fee`/`payment_received` ports.

## Interface
- `COIN0_VAL`, default 1: credit units for `coin_sel`=0
- `COIN1_VAL`, default 5: credit units for `coin_sel`=1
- `COIN2_VAL`, default 10: credit units for `coin_sel`=2
- `COIN3_VAL`, default 20: credit units for `coin_sel`=3
- `TIMEOUT_CYC`, default 1000: idle cycles in COLLECT before auto-refund (≥2)
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  synchronous, active-low reset
- `fee_ready`  in  1  billing ready level from the parking system
- `fee`  in  32  fee in credit units, valid while `fee_ready`=1
- `coin_valid`  in  1  one-cycle strobe, one coin accepted
- `coin_sel`  in  2  denomination of the strobed coin
- `cancel`  in  1  user abort, level or pulse
- `payment_received`  out  1  one-cycle pulse, fee fully paid
- `amount_due`  out  32  latched fee minus credit, floored at 0
- `credit`  out  32  credit collected in the current transaction
- `change_valid`  out  1  one-cycle pulse, coincident with `payment_received`
- `change_amount`  out  32  credit − fee, valid with `change_valid`
- `refund_valid`  out  1  one-cycle pulse on cancel or timeout
- `refund_amount`  out  32  credit returned, valid with `refund_valid`
- `coin_reject`  out  1  one-cycle pulse, coin strobed outside COLLECT
- `busy`  out  1  high in COLLECT, PAID and REFUND

## Operation
- States: IDLE, COLLECT, PAID, REFUND.
- IDLE: on a `fee_ready` 0→1 edge, latch `fee` into `due_reg`, clear `credit`, load the timer and go to COLLECT. If `fee`=0, go straight to PAID. A held `fee_ready` level never retriggers.
- COLLECT:
  - Each `coin_valid` adds COINn_VAL to `credit`. The add saturates at 32'hFFFF_FFFF.
  - A coin reloads the timer. With no coin, the timer decrements each cycle.
  - Go to PAID when next-credit ≥ `due_reg`. This takes priority over `cancel` and timeout in the same cycle.
  - Otherwise go to REFUND when `cancel`=1 or the timer reaches 0.
  - A coin arriving in the same cycle as `cancel` is counted into the refund.
  - A coin arriving in the timeout cycle reloads the timer, so no refund occurs.
- PAID (one cycle):
  - Assert `payment_received` and `change_valid`.
  - `change_amount` = `credit` − `due_reg`.
  - Next state IDLE. `credit` clears on entry to IDLE.
- REFUND (one cycle):
  - Assert `refund_valid`.
  - `refund_amount` = `credit`.
  - Next state IDLE.
- `coin_valid` in IDLE, PAID or REFUND: raise `coin_reject` for one cycle and leave `credit` unchanged.
- `amount_due` = `due_reg` > `credit` ? `due_reg` − `credit` : 0. It is registered.
- Reset values: all outputs 0, state IDLE, `due_reg`=0, timer=0, `fee_ready` edge register=0.

## Timing
- All outputs are registered.
- A coin strobed in cycle N is reflected in `credit` and `amount_due` in cycle N+1.
- When the coin in cycle N completes payment, `payment_received` is high in cycle N+1 only.
- Rising `fee_ready` in cycle N: state is COLLECT in N+1, with `amount_due`=`fee`.
- Zero fee: `payment_received` is high in N+1.
- Timeout: a refund fires TIMEOUT_CYC cycles after the last coin, or after COLLECT entry if no coin arrives.
- A new `fee_ready` edge during PAID or REFUND is ignored. A new transaction needs `fee_ready` to fall and rise again.
- `rst` low in any state returns to IDLE on the next edge. A mid-transaction credit is discarded and no refund pulse is issued.

## Structure
- Package `pay_pkg`:
  - state enum {IDLE, COLLECT, PAID, REFUND}
  - `FEE_W`=32
  - function mapping `coin_sel` to value from the parameters
- Sub-module `pay_timeout_timer`:
  - loadable down-counter of width $clog2(TIMEOUT_CYC+1)
  - inputs `load` and `en`
  - output `expired`
- Top-level FSM, credit adder and output registers live in `pay_station_ctrl`.

## Test plan
- Fee 12, coins 10 then 5 → `credit` 10 then 15; `payment_received` and `change_valid` pulse for one cycle with `change_amount`=3; `busy` drops the next cycle.
- Fee 0 → `payment_received` one cycle after the `fee_ready` rise, with `change_amount`=0.
- Fee 30, coin 20, then `cancel` together with a coin of 5 → `refund_valid` with `refund_amount`=25; no `payment_received`.
- Fee 7, TIMEOUT_CYC=8, one coin of 1 then idle → `refund_valid` with `refund_amount`=1 exactly 8 cycles after the coin. Repeat with a coin landing in the expiry cycle → no refund.
- Coin strobed in IDLE, and `fee_ready` held high across two transactions → `coin_reject` pulses and `credit` stays 0; no second transaction starts until `fee_ready` toggles.
- `rst` low during COLLECT with `credit`=15 → next cycle all outputs are 0 and state is IDLE, with no `refund_valid`.

Source files
------------

// File: rtl/pay_pkg.sv
// pay_pkg: shared types and helpers for the exit pay station.
//   pay_state_t  : controller state (IDLE, COLLECT, PAID, REFUND)
//   FEE_W        : width of fee / credit / change / refund values
//   coin_value() : maps a coin_sel code to its credit value
package pay_pkg;

  localparam int FEE_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAID    = 2'd2,
    REFUND  = 2'd3
  } pay_state_t;

  // The denomination table lives in the top-level parameters, so the
  // values are passed in rather than hard-coded here.
  function automatic logic [FEE_W-1:0] coin_value(
    input logic [1:0]       sel,
    input logic [FEE_W-1:0] v0,
    input logic [FEE_W-1:0] v1,
    input logic [FEE_W-1:0] v2,
    input logic [FEE_W-1:0] v3
  );
    case (sel)
      2'd0:    return v0;
      2'd1:    return v1;
      2'd2:    return v2;
      default: return v3;
    endcase
  endfunction

endpackage

// File: rtl/pay_timeout_timer.sv
// pay_timeout_timer: loadable inactivity down-counter.
//   clk, rst (sync, active-low)
//   load    : reload the counter (wins over en)
//   en      : count down by one, stops at zero
//   expired : counter is at zero
// The counter is loaded with TIMEOUT_CYC-2 in the load cycle. It then reads
// zero TIMEOUT_CYC-1 cycles later, which is the last cycle in which a coin
// can still rescue the transaction; the refund pulse shows one cycle after
// that, i.e. exactly TIMEOUT_CYC cycles after the load cycle.
module pay_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pay_station_ctrl.sv
// pay_station_ctrl: exit-side pay station controller.
//   Params  : COIN0..3_VAL coin credit values, TIMEOUT_CYC inactivity limit
//   Inputs  : clk, rst (sync, active-low), fee_ready, fee, coin_valid,
//             coin_sel, cancel
//   Outputs : payment_received, amount_due, credit, change_valid,
//             change_amount, refund_valid, refund_amount, coin_reject, busy,
//             state_dbg (current FSM state)
// Handshake: a transaction starts on a 0->1 edge of fee_ready (fee sampled in
// that cycle). A held level never starts another. coin_valid is a one-cycle
// strobe per accepted coin. Every output is a register, so all responses
// appear the cycle after the input that caused them.
import pay_pkg::*;

module pay_station_ctrl #(
  parameter int unsigned COIN0_VAL   = 1,
  parameter int unsigned COIN1_VAL   = 5,
  parameter int unsigned COIN2_VAL   = 10,
  parameter int unsigned COIN3_VAL   = 20,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fee_ready,
  input  logic [FEE_W-1:0] fee,
  input  logic             coin_valid,
  input  logic [1:0]       coin_sel,
  input  logic             cancel,
  output logic             payment_received,
  output logic [FEE_W-1:0] amount_due,
  output logic [FEE_W-1:0] credit,
  output logic             change_valid,
  output logic [FEE_W-1:0] change_amount,
  output logic             refund_valid,
  output logic [FEE_W-1:0] refund_amount,
  output logic             coin_reject,
  output logic             busy,
  output pay_state_t       state_dbg
);

  pay_state_t       state, next_state;
  logic             fee_ready_q;
  logic [FEE_W-1:0] due_reg;
  logic             fee_rise;
  logic [FEE_W-1:0] coin_val;
  logic [FEE_W:0]   coin_sum;
  logic [FEE_W-1:0] credit_next;
  logic             timer_load, timer_en, timer_expired;

  // Next-cycle register values produced by the output process.
  logic [FEE_W-1:0] due_d, credit_d, amount_due_d, change_amount_d, refund_amount_d;
  logic             pay_d, refund_d, reject_d;

  // The edge register tracks fee_ready in every state, so an edge that
  // lands in PAID or REFUND is consumed there and cannot start a
  // transaction later from a still-high level.
  assign fee_rise = fee_ready && !fee_ready_q;

  assign coin_val = coin_value(coin_sel, FEE_W'(COIN0_VAL), FEE_W'(COIN1_VAL),
                               FEE_W'(COIN2_VAL), FEE_W'(COIN3_VAL));
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  // Saturating add: a carry out pins credit at all-ones.
  assign credit_next = !coin_valid  ? credit :
                       coin_sum[FEE_W] ? '1 : coin_sum[FEE_W-1:0];

  assign timer_load = ((state == IDLE) && fee_rise) || ((state == COLLECT) && coin_valid);
  assign timer_en   = (state == COLLECT);

  pay_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Payment wins over cancel and timeout; a coin in the
  // expiry cycle reloads the timer, so it blocks the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fee_rise) next_state = (fee == '0) ? PAID : COLLECT;
      end
      COLLECT: begin
        if (credit_next >= due_reg) begin
          next_state = PAID;
        end else if (cancel || (timer_expired && !coin_valid)) begin
          next_state = REFUND;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values for every output register.
  always_comb begin
    due_d           = due_reg;
    credit_d        = credit;
    pay_d           = 1'b0;
    change_amount_d = '0;
    refund_d        = 1'b0;
    refund_amount_d = '0;
    reject_d        = coin_valid && (state != COLLECT);
    case (state)
      IDLE: begin
        if (fee_rise) begin
          due_d    = fee;
          credit_d = '0;
          pay_d    = (next_state == PAID);
        end
      end
      COLLECT: begin
        credit_d = credit_next;
        if (next_state == PAID) begin
          pay_d           = 1'b1;
          change_amount_d = credit_next - due_reg;
        end else if (next_state == REFUND) begin
          refund_d        = 1'b1;
          refund_amount_d = credit_next;
        end
      end
      default: begin
        // Transaction finished: nothing owed, nothing held.
        due_d    = '0;
        credit_d = '0;
      end
    endcase
    amount_due_d = (due_d > credit_d) ? (due_d - credit_d) : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fee_ready_q      <= 1'b0;
      due_reg          <= '0;
      credit           <= '0;
      amount_due       <= '0;
      payment_received <= 1'b0;
      change_valid     <= 1'b0;
      change_amount    <= '0;
      refund_valid     <= 1'b0;
      refund_amount    <= '0;
      coin_reject      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      fee_ready_q      <= fee_ready;
      due_reg          <= due_d;
      credit           <= credit_d;
      amount_due       <= amount_due_d;
      payment_received <= pay_d;
      change_valid     <= pay_d;
      change_amount    <= change_amount_d;
      refund_valid     <= refund_d;
      refund_amount    <= refund_amount_d;
      coin_reject      <= reject_d;
      busy             <= (next_state != IDLE);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pay_station_ctrl.sv
// tb_pay_station_ctrl: scoreboard bench for pay_station_ctrl.
// The driver applies one cycle of inputs, advances a transaction-level model
// and pushes the expected responses (tagged with the cycle in which they must
// appear) into queues; a negedge monitor pops and compares them.
module tb_pay_station_ctrl;
  import pay_pkg::*;

  localparam int T = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fee_ready = 1'b0;
  logic [31:0] fee = '0;
  logic        coin_valid = 1'b0;
  logic [1:0]  coin_sel = '0;
  logic        cancel = 1'b0;
  logic        payment_received, change_valid, refund_valid, coin_reject, busy;
  logic [31:0] amount_due, credit, change_amount, refund_amount;
  pay_state_t  state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pay_station_ctrl #(
    .COIN0_VAL(1), .COIN1_VAL(5), .COIN2_VAL(10), .COIN3_VAL(20), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .fee_ready(fee_ready), .fee(fee),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .cancel(cancel),
    .payment_received(payment_received), .amount_due(amount_due), .credit(credit),
    .change_valid(change_valid), .change_amount(change_amount),
    .refund_valid(refund_valid), .refund_amount(refund_amount),
    .coin_reject(coin_reject), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard queues ----------------
  logic [64:0] exp_q[$];   // {tag, is_refund, amount}
  logic [31:0] rej_q[$];   // tags of expected coin_reject pulses
  logic [97:0] snap_q[$];  // {tag, credit, amount_due, busy, after_reset}

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // phase 0: no transaction, 1: collecting coins, 2: pay/refund cycle
  int          m_phase = 0;
  logic [31:0] m_due = '0, m_credit = '0;
  logic        m_prev_fr = 1'b0;
  int          m_last = 0;   // cycle of the last timer restart (start or coin)
  int unsigned coin_tab[4] = '{1, 5, 10, 20};

  task automatic drive(input logic r, input logic fr, input logic [31:0] f,
                       input logic cv, input logic [1:0] cs, input logic cn);
    logic [31:0]     tag;
    longint unsigned sum;
    logic            rise;
    rst = r; fee_ready = fr; fee = f; coin_valid = cv; coin_sel = cs; cancel = cn;
    tag = cyc + 1;
    if (!r) begin
      m_phase = 0; m_due = '0; m_credit = '0; m_prev_fr = 1'b0;
    end else begin
      rise = fr && !m_prev_fr;
      m_prev_fr = fr;
      if (m_phase == 0) begin
        if (cv) rej_q.push_back(tag);
        if (rise) begin
          m_due = f; m_credit = '0;
          if (f == 0) begin
            exp_q.push_back({tag, 1'b0, 32'd0});
            m_phase = 2;
          end else begin
            m_phase = 1; m_last = cyc;
          end
        end
      end else if (m_phase == 1) begin
        if (cv) begin
          sum = 64'(m_credit) + 64'(coin_tab[cs]);
          m_credit = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
          m_last = cyc;
        end
        if (m_credit >= m_due) begin
          exp_q.push_back({tag, 1'b0, m_credit - m_due});
          m_phase = 2;
        end else if (cn || (cyc - m_last >= T - 1)) begin
          exp_q.push_back({tag, 1'b1, m_credit});
          m_phase = 2;
        end
      end else begin
        if (cv) rej_q.push_back(tag);
        m_phase = 0; m_credit = '0; m_due = '0;
      end
    end
    snap_q.push_back({tag, m_credit, (m_due > m_credit) ? m_due - m_credit : 32'd0,
                      m_phase != 0, !r});
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic fr, input logic [31:0] f, input logic cv,
                      input logic [1:0] cs, input logic cn);
    drive(1'b1, fr, f, cv, cs, cn);
  endtask

  task automatic idle(input logic fr, input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) step(fr, f, 1'b0, 2'd0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [97:0] s;
    logic [64:0] e;
    if (snap_q.size() > 0 && snap_q[0][97:66] == cyc) begin
      s = snap_q.pop_front();
      chk("credit", credit, s[65:34]);
      chk("amount_due", amount_due, s[33:2]);
      chk("busy", {31'd0, busy}, {31'd0, s[1]});
      if (s[0]) begin
        chk("reset_pulses", {28'd0, payment_received, change_valid, refund_valid, coin_reject}, 32'd0);
        chk("reset_change_amount", change_amount, 32'd0);
        chk("reset_refund_amount", refund_amount, 32'd0);
        chk("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
      end
      if (exp_q.size() > 0 && exp_q[0][64:33] == cyc) begin
        e = exp_q.pop_front();
        if (!e[32]) begin
          chk("pay_pulses", {29'd0, payment_received, change_valid, refund_valid}, 32'd6);
          chk("change_amount", change_amount, e[31:0]);
        end else begin
          chk("refund_pulses", {29'd0, payment_received, change_valid, refund_valid}, 32'd1);
          chk("refund_amount", refund_amount, e[31:0]);
        end
      end else begin
        chk("no_pulse", {29'd0, payment_received, change_valid, refund_valid}, 32'd0);
      end
      if (rej_q.size() > 0 && rej_q[0] == cyc) begin
        void'(rej_q.pop_front());
        chk("coin_reject", {31'd0, coin_reject}, 32'd1);
      end else begin
        chk("coin_reject_quiet", {31'd0, coin_reject}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        fr_r;
    logic [31:0] fee_r;
    int          coin_pct;

    // Reset, with a coin strobed during reset.
    drive(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 1'b0);
    idle(1'b0, 32'd0, 2);

    // Fee 12: coins 10 then 5, change 3. fee_ready stays high afterwards.
    step(1'b1, 32'd12, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd12, 1'b1, 2'd2, 1'b0);
    step(1'b1, 32'd12, 1'b1, 2'd1, 1'b0);
    idle(1'b1, 32'd12, 2);
    // Held level: coin in IDLE is rejected, no new transaction.
    step(1'b1, 32'd9, 1'b1, 2'd3, 1'b0);
    idle(1'b1, 32'd9, 3);
    idle(1'b0, 32'd0, 1);

    // Zero fee: immediate payment, change 0, coin in PAID rejected.
    step(1'b1, 32'd0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd0, 1'b1, 2'd0, 1'b0);
    idle(1'b0, 32'd0, 2);

    // Fee 30: coin 20, then cancel together with a coin of 5 -> refund 25.
    step(1'b1, 32'd30, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd30, 1'b1, 2'd3, 1'b0);
    step(1'b1, 32'd30, 1'b1, 2'd1, 1'b1);
    idle(1'b0, 32'd0, 3);

    // Fee 7: one coin of 1, then silence -> refund 1 at coin + T.
    step(1'b1, 32'd7, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd7, 1'b1, 2'd0, 1'b0);
    idle(1'b1, 32'd7, T + 2);
    idle(1'b0, 32'd0, 1);

    // Same, but a coin lands in the expiry cycle -> no refund there.
    step(1'b1, 32'd7, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd7, 1'b1, 2'd0, 1'b0);
    idle(1'b1, 32'd7, T - 2);
    step(1'b1, 32'd7, 1'b1, 2'd0, 1'b0);
    idle(1'b1, 32'd7, 3);
    step(1'b1, 32'd7, 1'b0, 2'd0, 1'b1);
    idle(1'b0, 32'd0, 2);

    // Reset during COLLECT with credit 15: no refund, everything cleared.
    step(1'b1, 32'd40, 1'b0, 2'd0, 1'b0);
    step(1'b1, 32'd40, 1'b1, 2'd2, 1'b0);
    step(1'b1, 32'd40, 1'b1, 2'd1, 1'b0);
    drive(1'b0, 1'b1, 32'd40, 1'b0, 2'd0, 1'b0);
    idle(1'b0, 32'd0, 3);

    // Randomized traffic.
    fr_r = 1'b0;
    fee_r = 32'd10;
    for (int i = 0; i < 3000; i++) begin
      coin_pct = ((i / 500) % 2 == 1) ? 40 : 12;
      if ($urandom_range(0, 99) < 8) fr_r = ~fr_r;
      if (!fr_r) begin
        case ($urandom_range(0, 19))
          0:       fee_r = 32'd0;
          1:       fee_r = 32'hFFFF_FF00;
          default: fee_r = $urandom_range(1, 60);
        endcase
      end
      drive($urandom_range(0, 199) != 0, fr_r, fee_r,
            $urandom_range(0, 99) < coin_pct, 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 3);
    end
    idle(1'b0, 32'd0, 2);

    @(negedge clk);
    #1;
    chk("queues_drained", exp_q.size() + rej_q.size() + snap_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
